fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of `controller`: owns the fetch PC, issues single-outstanding requests to a variable-latency instruction memory, and buffers returned words in a small FIFO. It presents the head entry as `Instr` with its PC to the decode/condition logic. A taken branch (`PCSrc`) redirects fetch, flushes the buffer, and squashes any in-flight response.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `DEPTH`, 2, instruction buffer entries (≥2)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `IMemReq`  out  1  fetch request valid
- `IMemAddr`  out  32  fetch address (= FetchPC)
- `IMemGnt`  in  1  memory accepts request this cycle
- `IMemRValid`  in  1  response data valid
- `IMemRData`  in  32  response instruction word
- `Instr`  out  32  head instruction to controller/datapath
- `InstrPC`  out  32  PC of `Instr`
- `InstrValid`  out  1  buffer non-empty
- `InstrTake`  in  1  consumer pops head (ignored when `InstrValid`=0)
- `PCSrc`  in  1  redirect fetch
- `BranchTarget`  in  32  redirect address (word aligned)

## Operation
- State machine (`fetch_state_t`): F_IDLE, F_REQ, F_WAIT, F_DRAIN. Reset state F_IDLE; F_IDLE → F_REQ unconditionally.
- F_REQ: `IMemReq` = (count < DEPTH). On `IMemReq && IMemGnt`: latch ReqPC = FetchPC, FetchPC += 4 (mod 2^32, wraps), → F_WAIT.
- F_WAIT: `IMemReq`=0. On `IMemRValid`: push {ReqPC, IMemRData}, → F_REQ.
- F_DRAIN: `IMemReq`=0. On `IMemRValid`: discard data, → F_REQ.
- Redirect (`PCSrc`=1), in any state except F_IDLE, has priority over all other events:
  - FetchPC ← `BranchTarget`, and the buffer is flushed.
  - Any pop that cycle is ignored.
  - F_REQ with `IMemGnt` same cycle → F_DRAIN (granted request is stale). F_REQ without grant → stays F_REQ.
  - F_WAIT without `IMemRValid` → F_DRAIN. F_WAIT with `IMemRValid` same cycle → data discarded, → F_REQ.
  - F_DRAIN → stays F_DRAIN until the response arrives, using the newest target.
- Buffer:
  - Circular with head/tail pointers and a count of width $clog2(DEPTH+1).
  - Simultaneous push and pop is legal at any occupancy.
  - Overflow is impossible: requests are gated on count < DEPTH, and count is never decremented speculatively.
- Outputs `Instr`/`InstrPC` show the head entry. They are don't-care when `InstrValid`=0, but are driven 0 after reset.

## Timing
- Reset (async assert) values:
  - `IMemReq`=0, `IMemAddr`=RESET_PC, `InstrValid`=0, `Instr`=0, `InstrPC`=0
  - state F_IDLE, count=0, pointers=0
- First `IMemReq`=1 in the 2nd rising edge after reset deassertion (F_IDLE → F_REQ).
- Grant at edge T → F_WAIT from T+1. Earliest `IMemRValid` is in cycle T+1.
- `IMemRValid` sampled at edge N → `InstrValid`=1 from N+1. There is no bypass from `IMemRData` to `Instr`.
- Peak throughput is 1 instruction per 2 cycles with zero-wait memory.
- Redirect sampled at edge R → `InstrValid`=0 and `IMemAddr`=BranchTarget from R+1.
- `IMemRValid` is only honoured in F_WAIT/F_DRAIN. Elsewhere it is ignored (protocol error, not checked).
- Reset asserted mid-transaction returns immediately to reset values. Any response arriving after reset release before a new grant is ignored.

## Structure
- `fetch_pkg`:
  - `fetch_state_t` enum
  - `INSTR_W`=32, `PC_W`=32, `PC_INC`=4
  - buffer entry struct {pc, instr}
- Sub-module `fetch_buffer`: parameterised DEPTH FIFO of entries with push/pop/flush, count, empty/full.
- `fetch_unit` keeps the FSM, FetchPC/ReqPC registers, and request gating.

## Test plan
- Reset release, memory grants immediately and responds next cycle with 32'hE3A0_1005 → `IMemAddr` 0,4,8…; after first response `Instr`=E3A01005, `InstrPC`=0, `InstrValid`=1.
- `InstrTake`=0 throughout → exactly 2 words buffered, `IMemReq` stays 0 with count=2. Single `InstrTake` → exactly one new request issued at the next PC (8).
- Memory latency 5 cycles, `PCSrc`=1 with `BranchTarget`=32'h100 during F_WAIT → stale response discarded; next request address 0x100; first valid `InstrPC`=0x100.
- `PCSrc` and `IMemGnt` in the same F_REQ cycle (target 0x40) → F_DRAIN, one response dropped, then request at 0x40.
- `RESET_PC`=32'hFFFF_FFFC → second request address wraps to 0x0000_0000.
- Reset asserted while in F_WAIT, with response arriving 2 cycles after release → all outputs at reset values, late response not pushed, first `InstrPC`=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_REQ   = 2'd1,
    F_WAIT  = 2'd2,
    F_DRAIN = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: instruction-memory request/response plus decode handoff.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic               IMemReq;
  logic [PC_W-1:0]    IMemAddr;
  logic               IMemGnt;
  logic               IMemRValid;
  logic [INSTR_W-1:0] IMemRData;
  logic [INSTR_W-1:0] Instr;
  logic [PC_W-1:0]    InstrPC;
  logic               InstrValid;
  logic               InstrTake;
  logic               PCSrc;
  logic [PC_W-1:0]    BranchTarget;

  // Fetch unit side.
  modport master (
    output IMemReq, IMemAddr, Instr, InstrPC, InstrValid,
    input  IMemGnt, IMemRValid, IMemRData, InstrTake, PCSrc, BranchTarget
  );

  // Memory / consumer side.
  modport slave (
    input  IMemReq, IMemAddr, Instr, InstrPC, InstrValid,
    output IMemGnt, IMemRValid, IMemRData, InstrTake, PCSrc, BranchTarget
  );
endinterface

// File: rtl/fetch_buffer.sv
// Circular instruction buffer: push/pop/flush, head entry shown combinationally.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  fetch_entry_t     i_data,
  output fetch_entry_t     o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);
  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_full, w_push, w_pop;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  // A push into a full buffer is only safe when the head leaves the same cycle.
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer, occupancy and storage update; flush wins over push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= i_data;
        r_tail        <= nxt(r_tail);
      end
      if (w_pop) r_head <= nxt(r_head);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding request FSM, PC tracking, redirect/squash.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_t     r_state;
  logic [PC_W-1:0]  r_fetch_pc, r_req_pc;
  logic             w_req, w_fire, w_flush, w_push, w_pop, w_empty;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head, w_push_data;

  // Only request when a slot is guaranteed for the response.
  assign w_req   = (r_state == F_REQ) && (w_count < CNT_W'(DEPTH));
  assign w_fire  = w_req && bus.IMemGnt;
  assign w_flush = bus.PCSrc && (r_state != F_IDLE);
  assign w_push  = (r_state == F_WAIT) && bus.IMemRValid && !w_flush;
  assign w_pop   = bus.InstrTake && !w_flush;

  assign w_push_data.pc    = r_req_pc;
  assign w_push_data.instr = bus.IMemRData;

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  // Fetch FSM; a redirect overrides the normal grant/response path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= F_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
    end else begin
      case (r_state)
        F_IDLE: r_state <= F_REQ;
        F_REQ: begin
          if (bus.PCSrc) begin
            r_fetch_pc <= bus.BranchTarget;
            // A request granted alongside the redirect is for the old path.
            if (w_fire) r_state <= F_DRAIN;
          end else if (w_fire) begin
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + PC_INC;
            r_state    <= F_WAIT;
          end
        end
        F_WAIT: begin
          if (bus.PCSrc) r_fetch_pc <= bus.BranchTarget;
          if (bus.IMemRValid)  r_state <= F_REQ;
          else if (bus.PCSrc)  r_state <= F_DRAIN;
        end
        F_DRAIN: begin
          if (bus.PCSrc) r_fetch_pc <= bus.BranchTarget;
          if (bus.IMemRValid) r_state <= F_REQ;
        end
        default: r_state <= F_IDLE;
      endcase
    end
  end

  assign bus.IMemReq    = w_req;
  assign bus.IMemAddr   = r_fetch_pc;
  assign bus.Instr      = w_head.instr;
  assign bus.InstrPC    = w_head.pc;
  assign bus.InstrValid = !w_empty;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized memory/consumer traffic,
// all cycles checked against a transaction-level model of the fetch stage.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic clk, reset;
  int   checks = 0, errors = 0;

  fetch_unit_if ifc ();
  fetch_unit_if ifc2 ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(ifc.master));

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .reset(reset), .bus(ifc2.master));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  fetch_entry_t mq[$];
  logic [31:0]  m_fpc, m_reqpc;
  bit           m_started, m_out, m_stale;

  function automatic void mreset();
    mq.delete();
    m_fpc = 32'h0; m_reqpc = 32'h0;
    m_started = 0; m_out = 0; m_stale = 0;
  endfunction

  // Compare at negedge, advance the model at posedge.
  initial begin
    bit req, do_push;
    fetch_entry_t e;
    mreset();
    forever begin
      @(negedge clk);
      if (!reset) begin
        mreset();
        chk("rst_req", {31'b0, ifc.IMemReq}, 32'd0);
        chk("rst_addr", ifc.IMemAddr, 32'h0);
        chk("rst_valid", {31'b0, ifc.InstrValid}, 32'd0);
        chk("rst_instr", ifc.Instr, 32'h0);
        chk("rst_pc", ifc.InstrPC, 32'h0);
      end else begin
        chk("req", {31'b0, ifc.IMemReq}, {31'b0, m_started && !m_out && (mq.size() < DEPTH)});
        chk("addr", ifc.IMemAddr, m_fpc);
        chk("valid", {31'b0, ifc.InstrValid}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) begin
          chk("instr", ifc.Instr, mq[0].instr);
          chk("instr_pc", ifc.InstrPC, mq[0].pc);
        end
      end
      @(posedge clk);
      if (!reset) mreset();
      else begin
        req = m_started && !m_out && (mq.size() < DEPTH);
        if (!m_started) m_started = 1;
        else if (ifc.PCSrc) begin
          mq.delete();
          if (req && ifc.IMemGnt) begin m_out = 1; m_stale = 1; end
          else if (m_out && ifc.IMemRValid) m_out = 0;
          else if (m_out) m_stale = 1;
          m_fpc = ifc.BranchTarget;
        end else begin
          do_push = 0;
          if (m_out && ifc.IMemRValid) begin
            do_push = !m_stale;
            m_out = 0;
          end
          if (ifc.InstrTake && mq.size() != 0) void'(mq.pop_front());
          if (do_push) begin
            e.pc = m_reqpc; e.instr = ifc.IMemRData;
            mq.push_back(e);
          end
          if (req && ifc.IMemGnt) begin
            m_out = 1; m_stale = 0;
            m_reqpc = m_fpc;
            m_fpc = m_fpc + 32'd4;
          end
        end
      end
    end
  end

  // ---------------- wrap-around instance monitor ----------------
  logic [31:0] a2[2];
  logic [31:0] pc2;
  initial begin
    int n;
    bit got;
    n = 0; got = 0;
    a2[0] = 32'h1234_5678; a2[1] = 32'h1234_5678; pc2 = 32'h1234_5678;
    wait (reset === 1'b0);
    wait (reset === 1'b1);
    repeat (20) begin
      @(negedge clk);
      if (ifc2.IMemReq && n < 2) begin a2[n] = ifc2.IMemAddr; n++; end
      if (ifc2.InstrValid && !got) begin pc2 = ifc2.InstrPC; got = 1; end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit g, input bit rv, input logic [31:0] d,
                       input bit tk, input bit pc, input logic [31:0] tg);
    ifc.IMemGnt = g; ifc.IMemRValid = rv; ifc.IMemRData = d;
    ifc.InstrTake = tk; ifc.PCSrc = pc; ifc.BranchTarget = tg;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.IMemGnt = 0; ifc.IMemRValid = 0; ifc.IMemRData = 0;
    ifc.InstrTake = 0; ifc.PCSrc = 0; ifc.BranchTarget = 0;
  endtask

  initial begin
    bit busy, gprev, g, rv, req_now;
    int lat;
    idle_inputs();
    ifc2.IMemGnt = 1; ifc2.IMemRValid = 1; ifc2.IMemRData = 32'hA5A5_0000;
    ifc2.InstrTake = 1; ifc2.PCSrc = 0; ifc2.BranchTarget = 32'h0;
    reset = 1;
    #1 reset = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("A_rst_req", {31'b0, ifc.IMemReq}, 32'd0);
    chk("A_rst_instr", ifc.Instr, 32'h0);
    reset = 1;

    // A: zero-wait memory, consumer stalled, then a single pop.
    drive(1, 0, 0, 0, 0, 0);
    chk("A_first_req", {31'b0, ifc.IMemReq}, 32'd1);
    chk("A_first_addr", ifc.IMemAddr, 32'h0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'hE3A0_1005, 0, 0, 0);
    chk("A_instr", ifc.Instr, 32'hE3A0_1005);
    chk("A_instr_pc", ifc.InstrPC, 32'h0);
    chk("A_addr4", ifc.IMemAddr, 32'h4);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'hCAFE_0001, 0, 0, 0);
    repeat (3) drive(1, 0, 0, 0, 0, 0);
    chk("A_full_noreq", {31'b0, ifc.IMemReq}, 32'd0);
    chk("A_full_head", ifc.InstrPC, 32'h0);
    drive(0, 0, 0, 1, 0, 0);
    chk("A_req_after_pop", {31'b0, ifc.IMemReq}, 32'd1);
    chk("A_addr8", ifc.IMemAddr, 32'h8);
    chk("A_next_head", ifc.Instr, 32'hCAFE_0001);

    // B: redirect while a slow response is outstanding.
    drive(1, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h100);
    chk("B_flush", {31'b0, ifc.InstrValid}, 32'd0);
    chk("B_tgt", ifc.IMemAddr, 32'h100);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("B_stale_dropped", {31'b0, ifc.InstrValid}, 32'd0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h1111_1111, 0, 0, 0);
    chk("B_new_pc", ifc.InstrPC, 32'h100);

    // C: redirect coincides with a grant.
    drive(1, 0, 0, 0, 1, 32'h40);
    chk("C_noreq", {31'b0, ifc.IMemReq}, 32'd0);
    drive(0, 1, 32'hBAD0_BAD0, 0, 0, 0);
    chk("C_dropped", {31'b0, ifc.InstrValid}, 32'd0);
    chk("C_addr", ifc.IMemAddr, 32'h40);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h2222_2222, 0, 0, 0);
    chk("C_pc", ifc.InstrPC, 32'h40);

    // D: reset in the middle of a transaction, late response afterwards.
    drive(1, 0, 0, 0, 0, 0);
    idle_inputs();
    #2 reset = 0;
    #1;
    chk("D_req", {31'b0, ifc.IMemReq}, 32'd0);
    chk("D_addr", ifc.IMemAddr, 32'h0);
    chk("D_valid", {31'b0, ifc.InstrValid}, 32'd0);
    chk("D_instr", ifc.Instr, 32'h0);
    @(posedge clk);
    #1 reset = 1;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 32'hBAD1_BAD1, 0, 0, 0);
    chk("D_late_ignored", {31'b0, ifc.InstrValid}, 32'd0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h3333_3333, 0, 0, 0);
    chk("D_pc", ifc.InstrPC, 32'h0);

    // Random traffic: variable latency, random grants, pops and redirects.
    busy = 0; gprev = 0; lat = 0;
    repeat (3000) begin
      req_now = ifc.IMemReq;
      if (gprev) begin busy = 1; lat = $urandom_range(0, 4); end
      rv = 0;
      if (busy) begin
        if (lat == 0) begin rv = 1; busy = 0; end
        else lat--;
      end
      g = ($urandom_range(0, 9) < 7);
      gprev = req_now && g;
      drive(g, rv, $urandom, ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) < 6),
            $urandom & 32'hFFFF_FFFC);
    end
    idle_inputs();
    repeat (2) @(posedge clk);

    chk("W_first_addr", a2[0], 32'hFFFF_FFFC);
    chk("W_wrap_addr", a2[1], 32'h0000_0000);
    chk("W_first_pc", pc2, 32'hFFFF_FFFC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
